// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM slave with wait states and error flagging
// Optional DMEM_STATS_EN adds saturating load/store/error response counters.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wstrb;
  logic [32:0]   acc_diff;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;
  logic          mem_we;
  logic          rsp_fire;

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the access operands come straight from the request port while idle.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_wr    = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_diff = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    acc_err  = acc_diff[32] | (|acc_diff[1:0]) | (|acc_diff[31:AW+2]);
    acc_idx  = acc_diff[AW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'(WAIT_STATES - 1);
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (acc_wr || acc_err) ? 32'd0 : mem[acc_idx];
      err_d   = acc_err;
    end
  end

  assign mem_we    = enter_resp && acc_wr && !acc_err && reset;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_fire  = (state_q == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] stat_loads_q, stat_loads_d;
  logic [15:0] stat_stores_q, stat_stores_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (rsp_fire) begin
      if (err_q) begin
        if (stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
      end else if (wr_q) begin
        if (stat_stores_q != 16'hFFFF) stat_stores_d = stat_stores_q + 16'd1;
      end else begin
        if (stat_loads_q != 16'hFFFF) stat_loads_d = stat_loads_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads_q  <= 16'd0;
      stat_stores_q <= 16'd0;
      stat_errs_q   <= 16'd0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that answers the CPU's load/store port through a valid/ready request channel and a valid/ready response channel.
- Holds a word-addressed RAM and applies byte-lane write strobes.
- Inserts a programmable number of wait states and flags misaligned or out-of-range accesses.
- Lets the core's data port be evaluated against a memory with non-zero latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of two, ≥4).
- WAIT_STATES, 1, extra cycles between request accept and response valid (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane enables; bit i selects wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (reset=0, async): FSM to IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0. RAM contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture write, addr, wdata and wstrb.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - The counter loads WAIT_STATES-1.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; move to RESP after the cycle in which the counter reads 0.
- Access point: the RAM is read and written on the clock edge that enters RESP.
  - Write: for each set strobe bit, update the corresponding byte lane.
  - Read: load the word into rsp_rdata.
  - rsp_rdata returns the contents before the access. Stores return 0, so there is no ambiguity.
- RESP:
  - rsp_valid=1; req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready.
  - On that handshake: next state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency:
  - rsp_valid rises WAIT_STATES+1 edges after the accept edge.
  - Minimum request-to-request spacing is WAIT_STATES+2 cycles.
  - There is no overlap: a request is never accepted in the same cycle as a response handshake.
- Address decode:
  - Word index = (addr-BASE_ADDR)>>2.
  - Error if addr[1:0]!=0, addr<BASE_ADDR, or addr≥BASE_ADDR+4*DEPTH_WORDS.
  - On error: no RAM write, rsp_rdata=0, rsp_err=1. The full response timing still applies.
- Strobes:
  - A store with wstrb=4'b0000 leaves the RAM unchanged and completes with rsp_err=0.
  - Loads ignore wstrb and always return the full word.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely. req_valid is ignored meanwhile.
- Reset asserted mid-transaction: the transaction is abandoned.
  - If reset arrives before the RESP-entry edge, no write occurs.
  - Outputs return to their reset values immediately.
- Request inputs are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores and stat_errs, each 16 bits.
  - Reset to 0.
  - Each increments by 1 on the response handshake of the matching transaction class. An error counts only in stat_errs.
  - Each saturates at 16'hFFFF.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
1. Defaults, store then load:
   - Stimulus: store addr 0x10, wdata 0xDEADBEEF, wstrb 1111; then load addr 0x10.
   - Required: rsp_valid 2 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte strobes:
   - Stimulus: after test 1, store addr 0x10, wdata 0x00000055, wstrb 0001; then load addr 0x10.
   - Required: load returns 0xDEADBE55.
3. Errors:
   - Stimulus: load addr 0x12, then store to 0x400 (DEPTH_WORDS=256).
   - Required: both give rsp_err=1, rsp_rdata=0; a later load of 0x0 is unchanged.
4. Backpressure:
   - Stimulus: hold rsp_ready=0 for 5 cycles during a load; drive a second req_valid meanwhile.
   - Required: rsp_valid stays 1 and rsp_rdata stays stable; req_ready=0; the second request is accepted only after the handshake.
5. Reset mid-operation:
   - Stimulus: WAIT_STATES=3; store 0x12345678 to 0x20; assert reset one cycle after accept; release; load 0x20.
   - Required: load returns the old value; rsp_valid=0 during reset.
6. WAIT_STATES=0 and DMEM_STATS_EN defined:
   - Stimulus: back-to-back load, store, error load.
   - Required: each response is 1 cycle after accept; stat_loads=1, stat_stores=1, stat_errs=1.
